// File: rtl/debug_pkg.sv
// Constants shared by the debug path: latch widths, dump framing and serializer states.
package debug_pkg;

  localparam int unsigned IF_ID_W    = 64;
  localparam int unsigned ID_EX_W    = 139;
  localparam int unsigned EX_MEM_W   = 76;
  localparam int unsigned MEM_WB_W   = 71;
  localparam int unsigned SNAP_W     = IF_ID_W + ID_EX_W + EX_MEM_W + MEM_WB_W;
  localparam int unsigned SNAP_PAD_W = 352;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_CNT   = SNAP_PAD_W / WORD_W;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned PAD_W      = SNAP_PAD_W - SNAP_W;

  localparam logic [7:0] DUMP_HEADER_TAG = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/latch_dump_serializer.sv
// Snapshots the four pipeline latches on start and streams them, behind a header
// word, into the transmit FIFO while honouring its full flag.
module latch_dump_serializer
  import debug_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  HEADER_TAG = DUMP_HEADER_TAG
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [IF_ID_W-1:0]    i_IF_ID_latch,
  input  logic [ID_EX_W-1:0]    i_ID_EX_latch,
  input  logic [EX_MEM_W-1:0]   i_EX_MEM_latch,
  input  logic [MEM_WB_W-1:0]   i_MEM_WB_latch,
  input  logic                  i_fifo_full,
  output logic [DATA_WIDTH-1:0] o_data_to_fifo,
  output logic                  o_write_en_fifo,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_CNT);

  dump_state_e                          state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [WORD_CNT-1:0][WORD_W-1:0]      snap_q, snap_d;
  logic [IDX_W-1:0]                     word_sel;
  logic [WORD_W-1:0]                    header;

  assign header   = {HEADER_TAG, 8'(WORD_CNT), 16'h0000};
  assign word_sel = idx_q - IDX_W'(1);

  // State, index and snapshot registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Next-state: capture on accepted start, advance only on an accepted write
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_d  = {PAD_W'(0), i_MEM_WB_latch, i_EX_MEM_latch, i_ID_EX_latch, i_IF_ID_latch};
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!i_fifo_full) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Word mux: header at idx 0, snapshot words least significant first after it
  always_comb begin
    o_data_to_fifo = '0;
    if (state_q == SEND) begin
      if (idx_q == '0) begin
        o_data_to_fifo = DATA_WIDTH'(header);
      end else if (idx_q <= LAST_IDX) begin
        o_data_to_fifo = DATA_WIDTH'(snap_q[word_sel]);
      end
    end
  end

  assign o_write_en_fifo = (state_q == SEND) & ~i_fifo_full;
  assign o_busy          = (state_q != IDLE);
  assign o_done          = (state_q == DONE);

endmodule
